// File: rtl/exec_pkg.sv
// Shared types and constants for the execute/write-back stage.
//   alu_op_t   : 3-bit opcode (ADD..NOP)
//   ex_state_t : EX occupancy state (IDLE / MUL_BUSY)
//   DATA_W, REG_IDX_W, MUL_CYCLES and derived counter constants
package exec_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_IDX_W  = 2;
  localparam int OP_W       = 3;
  localparam int MUL_CYCLES = DATA_W;
  localparam int MUL_CNT_W  = $clog2(MUL_CYCLES);
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_MUL = 3'b110,
    OP_NOP = 3'b111
  } alu_op_t;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } ex_state_t;

endpackage

// File: rtl/exec_wb_stage_if.sv
// Bundle of the issue handshake and the register-file ports.
//   master : issue side + register file (drives instruction, read data)
//   slave  : the exec_wb_stage (drives ready, read indices, write port)
interface exec_wb_stage_if;
  import exec_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [OP_W-1:0]      op;
  logic [REG_IDX_W-1:0] rs;
  logic [REG_IDX_W-1:0] rt;
  logic [REG_IDX_W-1:0] rd;
  logic [REG_IDX_W-1:0] rf_read_reg1;
  logic [REG_IDX_W-1:0] rf_read_reg2;
  logic [DATA_W-1:0]    rf_read_data1;
  logic [DATA_W-1:0]    rf_read_data2;
  logic                 rf_reg_write;
  logic [REG_IDX_W-1:0] rf_write_reg;
  logic [DATA_W-1:0]    rf_write_data;

  modport master (
    output instr_valid, op, rs, rt, rd, rf_read_data1, rf_read_data2,
    input  instr_ready, rf_read_reg1, rf_read_reg2,
           rf_reg_write, rf_write_reg, rf_write_data
  );

  modport slave (
    input  instr_valid, op, rs, rt, rd, rf_read_data1, rf_read_data2,
    output instr_ready, rf_read_reg1, rf_read_reg2,
           rf_reg_write, rf_write_reg, rf_write_data
  );

endinterface

// File: rtl/exec_alu.sv
// Single-cycle combinational ALU.
//   i_op     : opcode (MUL and NOP produce 0; MUL is handled by the top)
//   i_a, i_b : operands
//   o_result : ADD/SUB wrap, SLT signed 0/1, bitwise logic ops
module exec_alu
  import exec_pkg::*;
(
  input  alu_op_t           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/write-back stage for a 4x32 register file.
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : slave side of exec_wb_stage_if (issue handshake, two read
//                ports, one write port)
// EX holds one instruction; single-cycle ops go through exec_alu, MUL runs a
// 32-iteration shift-add. WB registers the final EX result and drives the
// write port. Operands are forwarded from EX (when final) then WB.
module exec_wb_stage
  import exec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  exec_wb_stage_if.slave   bus
);

  ex_state_t r_state, w_state_nxt;

  logic                 r_ex_vld;
  alu_op_t              r_ex_op;
  logic [REG_IDX_W-1:0] r_ex_rd;
  logic [DATA_W-1:0]    r_ex_a, r_ex_b;

  logic [DATA_W-1:0]    r_mul_acc, r_mul_mcand, r_mul_mplier;
  logic [MUL_CNT_W-1:0] r_mul_cnt;

  logic                 r_wb_we;
  logic [REG_IDX_W-1:0] r_wb_reg;
  logic [DATA_W-1:0]    r_wb_data;

  alu_op_t           w_op;
  logic              w_ready, w_accept, w_mul_busy;
  logic              w_ex_final, w_ex_fwd;
  logic [DATA_W-1:0] w_alu_res, w_mul_res, w_ex_res;
  logic [DATA_W-1:0] w_opa, w_opb;

  assign w_op              = alu_op_t'(bus.op);
  assign bus.rf_read_reg1  = bus.rs;
  assign bus.rf_read_reg2  = bus.rt;
  assign bus.instr_ready   = w_ready;
  assign bus.rf_reg_write  = r_wb_we;
  assign bus.rf_write_reg  = r_wb_reg;
  assign bus.rf_write_data = r_wb_data;

  exec_alu u_alu (
    .i_op     (r_ex_op),
    .i_a      (r_ex_a),
    .i_b      (r_ex_b),
    .o_result (w_alu_res)
  );

  // The last shift-add step is folded in combinationally so the product is
  // available in the cycle where mul_cnt reaches its final value.
  assign w_mul_res  = r_mul_acc + (r_mul_mplier[0] ? r_mul_mcand : '0);
  assign w_ex_res   = (r_ex_op == OP_MUL) ? w_mul_res : w_alu_res;
  assign w_ex_final = (r_ex_op != OP_MUL) || (r_mul_cnt == MUL_LAST);
  assign w_ex_fwd   = r_ex_vld && (r_ex_op != OP_NOP) && w_ex_final;

  // EX beats WB when both hold the same index (EX is the younger write).
  assign w_opa = (w_ex_fwd && r_ex_rd == bus.rs)   ? w_ex_res  :
                 (r_wb_we  && r_wb_reg == bus.rs)  ? r_wb_data :
                                                     bus.rf_read_data1;
  assign w_opb = (w_ex_fwd && r_ex_rd == bus.rt)   ? w_ex_res  :
                 (r_wb_we  && r_wb_reg == bus.rt)  ? r_wb_data :
                                                     bus.rf_read_data2;

  assign w_accept = bus.instr_valid && w_ready;

  // FSM: next state and issue-ready.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_mul_busy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_op == OP_MUL) w_state_nxt = S_MUL_BUSY;
      end
      S_MUL_BUSY: begin
        w_mul_busy = (r_mul_cnt != MUL_LAST);
        w_ready    = !w_mul_busy;
        if (!w_mul_busy)
          w_state_nxt = (w_accept && w_op == OP_MUL) ? S_MUL_BUSY : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // EX register: holds while a MUL is iterating, otherwise loads the new
  // instruction or a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_vld <= 1'b0;
      r_ex_op  <= OP_NOP;
      r_ex_rd  <= '0;
      r_ex_a   <= '0;
      r_ex_b   <= '0;
    end else if (w_ready) begin
      r_ex_vld <= bus.instr_valid;
      r_ex_op  <= bus.instr_valid ? w_op : OP_NOP;
      r_ex_rd  <= bus.rd;
      r_ex_a   <= w_opa;
      r_ex_b   <= w_opb;
    end
  end

  // Multiplier: unsigned shift-add, low DATA_W bits kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_acc    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
      r_mul_cnt    <= '0;
    end else if (w_accept && w_op == OP_MUL) begin
      r_mul_acc    <= '0;
      r_mul_mcand  <= w_opa;
      r_mul_mplier <= w_opb;
      r_mul_cnt    <= '0;
    end else if (w_mul_busy) begin
      r_mul_acc    <= w_mul_res;
      r_mul_mcand  <= r_mul_mcand << 1;
      r_mul_mplier <= r_mul_mplier >> 1;
      r_mul_cnt    <= r_mul_cnt + 1'b1;
    end else begin
      r_mul_cnt    <= '0;
    end
  end

  // WB register: captures EX only once its result is final.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_we   <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_data <= '0;
    end else if (w_ex_final) begin
      r_wb_we   <= r_ex_vld && (r_ex_op != OP_NOP);
      r_wb_reg  <= r_ex_rd;
      r_wb_data <= w_ex_res;
    end else begin
      r_wb_we   <= 1'b0;
    end
  end

endmodule
